// File: rtl/cardinal_nic.sv
// Network interface between a processor register port and a router channel.
// One-entry input and output buffers, each with a full flag; output injection is gated by VC polarity.
module cardinal_nic #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [0:1]            addr,
   input  logic [0:DATA_WIDTH-1] d_in,
   output logic [0:DATA_WIDTH-1] d_out,
   input  logic                  nicEn,
   input  logic                  nicWrEn,
   input  logic                  net_si,
   output logic                  net_ri,
   input  logic [0:DATA_WIDTH-1] net_di,
   output logic                  net_so,
   input  logic                  net_ro,
   output logic [0:DATA_WIDTH-1] net_do,
   input  logic                  net_polarity
);

   logic [0:DATA_WIDTH-1] r_in_buf;
   logic [0:DATA_WIDTH-1] r_out_buf;
   logic                  r_in_full;
   logic                  r_out_full;

   logic                  w_rd;
   logic                  w_wr;
   logic                  w_in_accept;
   logic                  w_in_drain;
   logic                  w_out_load;
   logic                  w_send;
   logic [0:DATA_WIDTH-1] w_in_stat;
   logic [0:DATA_WIDTH-1] w_out_stat;

   assign w_rd        = nicEn & ~nicWrEn;
   assign w_wr        = nicEn & nicWrEn;
   assign w_in_accept = net_si & ~r_in_full;
   assign w_in_drain  = w_rd & (addr == 2'b00) & r_in_full;
   assign w_out_load  = w_wr & (addr == 2'b10) & ~r_out_full;
   // Bit 0 of the held packet carries its virtual channel.
   assign w_send      = r_out_full & net_ro & (r_out_buf[0] == net_polarity);

   assign net_ri = ~r_in_full;
   assign net_so = w_send;
   assign net_do = r_out_buf;

   // Status registers carry their flag in the LSB (bit DATA_WIDTH-1).
   always_comb begin
      w_in_stat                 = '0;
      w_out_stat                = '0;
      w_in_stat[DATA_WIDTH-1]   = r_in_full;
      w_out_stat[DATA_WIDTH-1]  = r_out_full;
   end

   always_comb begin
      d_out = '0;
      if (w_rd) begin
         case (addr)
            2'b00:   d_out = r_in_buf;
            2'b01:   d_out = w_in_stat;
            2'b10:   d_out = r_out_buf;
            default: d_out = w_out_stat;
         endcase
      end
   end

   // Accept and drain are mutually exclusive: accept needs an empty buffer, drain a full one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_in_buf  <= '0;
         r_in_full <= 1'b0;
      end else if (w_in_accept) begin
         r_in_buf  <= net_di;
         r_in_full <= 1'b1;
      end else if (w_in_drain) begin
         r_in_full <= 1'b0;
      end
   end

   // A write while full is dropped even in the send cycle, since load requires out_full=0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_buf  <= '0;
         r_out_full <= 1'b0;
      end else if (w_out_load) begin
         r_out_buf  <= d_in;
         r_out_full <= 1'b1;
      end else if (w_send) begin
         r_out_full <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed vector bench for cardinal_nic: per-cycle stimulus rows with expected combinational outputs,
// plus a hand sequence for asynchronous reset while both buffers are full.
module tb_cardinal_nic;

   logic        clk;
   logic        reset;
   logic [0:1]  addr;
   logic [0:63] d_in;
   logic [0:63] d_out;
   logic        nicEn;
   logic        nicWrEn;
   logic        net_si;
   logic        net_ri;
   logic [0:63] net_di;
   logic        net_so;
   logic        net_ro;
   logic [0:63] net_do;
   logic        net_polarity;

   int n_tests = 0;
   int n_fail  = 0;

   cardinal_nic #(.DATA_WIDTH(64)) dut (
      .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
      .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
      .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
      .net_polarity(net_polarity)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        wr;
      logic [0:1]  ad;
      logic [0:63] din;
      logic        si;
      logic [0:63] di;
      logic        ro;
      logic        pol;
      logic [0:63] e_dout;
      logic        e_ri;
      logic        e_so;
      logic [0:63] e_do;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic en, input logic wr, input logic [1:0] ad,
                               input logic [63:0] din, input logic si, input logic [63:0] di,
                               input logic ro, input logic pol, input logic [63:0] e_dout,
                               input logic e_ri, input logic e_so, input logic [63:0] e_do);
      vec_t v;
      v.en = en; v.wr = wr; v.ad = ad; v.din = din; v.si = si; v.di = di;
      v.ro = ro; v.pol = pol; v.e_dout = e_dout; v.e_ri = e_ri; v.e_so = e_so; v.e_do = e_do;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic wr, input logic [1:0] ad, input logic [63:0] din,
                        input logic si, input logic [63:0] di, input logic ro, input logic pol);
      nicEn = en; nicWrEn = wr; addr = ad; d_in = din;
      net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
   endtask

   localparam logic [63:0] PA  = 64'hA5A5_0000_0000_0001;
   localparam logic [63:0] PO  = 64'h8000_0000_0000_00FF;
   localparam logic [63:0] ONE = 64'h1;
   localparam logic [63:0] Z   = 64'h0;
   localparam logic [63:0] FF  = 64'hFFFF_FFFF_FFFF_FFFF;

   initial begin
      //          en wr ad     din     si di      ro pol  e_dout  ri so e_do
      vq.push_back(mk(0,0,2'b00,Z,     0,Z,      0,0,   Z,      1,0,Z));
      vq.push_back(mk(0,0,2'b00,Z,     1,PA,     0,0,   Z,      1,0,Z));
      vq.push_back(mk(1,0,2'b01,Z,     0,Z,      0,0,   ONE,    0,0,Z));
      vq.push_back(mk(1,0,2'b00,Z,     0,Z,      0,0,   PA,     0,0,Z));
      vq.push_back(mk(0,0,2'b00,Z,     0,Z,      0,0,   Z,      1,0,Z));
      vq.push_back(mk(1,0,2'b00,Z,     0,Z,      0,0,   PA,     1,0,Z));
      vq.push_back(mk(1,0,2'b01,Z,     0,Z,      0,0,   Z,      1,0,Z));
      vq.push_back(mk(0,0,2'b00,Z,     1,64'h1111,0,0,  Z,      1,0,Z));
      vq.push_back(mk(1,0,2'b01,Z,     1,64'hDEAD,0,0,  ONE,    0,0,Z));
      vq.push_back(mk(0,0,2'b00,Z,     1,64'hDEAD,0,0,  Z,      0,0,Z));
      vq.push_back(mk(0,0,2'b00,Z,     1,64'hDEAD,0,0,  Z,      0,0,Z));
      vq.push_back(mk(1,0,2'b00,Z,     0,Z,      0,0,   64'h1111,0,0,Z));
      vq.push_back(mk(0,0,2'b00,Z,     1,64'h2222,0,0,  Z,      1,0,Z));
      vq.push_back(mk(1,0,2'b00,Z,     0,Z,      0,0,   64'h2222,0,0,Z));
      // output path: VC mismatch holds, match sends for one cycle
      vq.push_back(mk(1,1,2'b10,PO,    0,Z,      1,0,   Z,      1,0,Z));
      vq.push_back(mk(1,0,2'b11,Z,     0,Z,      1,0,   ONE,    1,0,PO));
      vq.push_back(mk(0,0,2'b00,Z,     0,Z,      1,1,   Z,      1,1,PO));
      vq.push_back(mk(1,0,2'b11,Z,     0,Z,      1,1,   Z,      1,0,PO));
      vq.push_back(mk(1,1,2'b10,64'h5, 0,Z,      0,0,   Z,      1,0,PO));
      vq.push_back(mk(1,1,2'b10,64'h1234,0,Z,    0,0,   Z,      1,0,64'h5));
      vq.push_back(mk(0,0,2'b00,Z,     0,Z,      1,0,   Z,      1,1,64'h5));
      vq.push_back(mk(1,0,2'b11,Z,     0,Z,      1,0,   Z,      1,0,64'h5));
      // write during the send cycle is dropped
      vq.push_back(mk(1,1,2'b10,64'h7, 0,Z,      0,0,   Z,      1,0,64'h5));
      vq.push_back(mk(1,1,2'b10,64'h9, 0,Z,      1,0,   Z,      1,1,64'h7));
      vq.push_back(mk(1,0,2'b10,Z,     0,Z,      1,0,   64'h7,  1,0,64'h7));
      // writes to other addresses do nothing
      vq.push_back(mk(1,1,2'b00,FF,    0,Z,      0,0,   Z,      1,0,64'h7));
      vq.push_back(mk(1,1,2'b11,FF,    0,Z,      0,0,   Z,      1,0,64'h7));
      vq.push_back(mk(1,1,2'b01,FF,    0,Z,      0,0,   Z,      1,0,64'h7));
      vq.push_back(mk(1,0,2'b01,Z,     0,Z,      0,0,   Z,      1,0,64'h7));
      vq.push_back(mk(1,0,2'b11,Z,     0,Z,      0,0,   Z,      1,0,64'h7));
      vq.push_back(mk(1,0,2'b10,Z,     0,Z,      0,0,   64'h7,  1,0,64'h7));
      vq.push_back(mk(1,0,2'b00,Z,     0,Z,      0,0,   64'h2222,1,0,64'h7));
      // send, arrival and in-buf read all in one cycle
      vq.push_back(mk(1,1,2'b10,64'hA, 0,Z,      0,0,   Z,      1,0,64'h7));
      vq.push_back(mk(1,0,2'b00,Z,     1,64'hBEEF,1,0,  64'h2222,1,1,64'hA));
      vq.push_back(mk(1,0,2'b01,Z,     0,Z,      1,0,   ONE,    0,0,64'hA));
      vq.push_back(mk(1,0,2'b00,Z,     0,Z,      1,0,   64'hBEEF,0,0,64'hA));
      vq.push_back(mk(1,0,2'b11,Z,     0,Z,      1,0,   Z,      1,0,64'hA));
      // read-clear with arrival blocked in the same cycle
      vq.push_back(mk(0,0,2'b00,Z,     1,64'h3333,0,0,  Z,      1,0,64'hA));
      vq.push_back(mk(1,0,2'b00,Z,     1,64'h4444,0,0,  64'h3333,0,0,64'hA));
      vq.push_back(mk(1,0,2'b00,Z,     0,Z,      0,0,   64'h3333,1,0,64'hA));

      reset = 1'b0;
      drive(0,0,2'b00,Z,0,Z,0,0);
      #1;
      chk("reset ri", {63'b0, net_ri}, ONE);
      chk("reset so", {63'b0, net_so}, Z);
      chk("reset do", net_do, Z);
      chk("reset dout", d_out, Z);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].en, vq[i].wr, vq[i].ad, vq[i].din, vq[i].si, vq[i].di, vq[i].ro, vq[i].pol);
         #1;
         chk($sformatf("v%0d dout", i), d_out, vq[i].e_dout);
         chk($sformatf("v%0d ri", i), {63'b0, net_ri}, {63'b0, vq[i].e_ri});
         chk($sformatf("v%0d so", i), {63'b0, net_so}, {63'b0, vq[i].e_so});
         chk($sformatf("v%0d do", i), net_do, vq[i].e_do);
      end

      // async reset between edges with both buffers full
      @(negedge clk);
      drive(1,1,2'b10,64'h8000_0000_0000_0001,1,64'h5555,0,1);
      @(posedge clk);
      #2;
      drive(0,0,2'b00,Z,0,Z,1,1);
      #1;
      chk("full ri", {63'b0, net_ri}, Z);
      chk("full so", {63'b0, net_so}, ONE);
      reset = 1'b0;
      #1;
      chk("arst ri", {63'b0, net_ri}, ONE);
      chk("arst so", {63'b0, net_so}, Z);
      chk("arst do", net_do, Z);
      drive(1,0,2'b01,Z,0,Z,1,1); #1; chk("arst rd01", d_out, Z);
      drive(1,0,2'b11,Z,0,Z,1,1); #1; chk("arst rd11", d_out, Z);
      drive(1,0,2'b00,Z,0,Z,1,1); #1; chk("arst rd00", d_out, Z);
      drive(1,0,2'b10,Z,0,Z,1,1); #1; chk("arst rd10", d_out, Z);

      // traffic during reset is ignored
      @(negedge clk);
      drive(1,1,2'b10,64'h8000_0000_0000_0003,1,64'h6666,1,1);
      @(posedge clk);
      #1;
      chk("inrst ri", {63'b0, net_ri}, ONE);
      chk("inrst so", {63'b0, net_so}, Z);
      chk("inrst do", net_do, Z);

      @(negedge clk);
      drive(0,0,2'b00,Z,0,Z,1,1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rel ri", {63'b0, net_ri}, ONE);
      drive(1,0,2'b11,Z,0,Z,1,1); #1; chk("rel rd11", d_out, Z);

      @(negedge clk);
      drive(0,0,2'b00,Z,1,64'h77,0,0);
      @(posedge clk);
      #1;
      drive(1,0,2'b01,Z,0,Z,0,0); #1; chk("post rd01", d_out, ONE);
      drive(1,0,2'b00,Z,0,Z,0,0); #1; chk("post rd00", d_out, 64'h77);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
